// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared encodings for the byte-serialising memory bus front end
package mem_bus_arbiter_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DRAIN, ST_DONE} state_t;
    localparam logic [1:0] SIZE_1B = 2'd0;
    localparam logic [1:0] SIZE_2B = 2'd1;
    localparam logic [1:0] IO_TAG  = 2'b11;
    localparam int ARB_RR = 1;
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        return size == SIZE_1B ? 3'd1 : size == SIZE_2B ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// rr_arbiter: picks one requester, fixed priority or round-robin from a pointer; purely combinational
module rr_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int MODE      = 0,
    localparam int PW       = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PW-1:0]        grant_idx,
    output logic [PW-1:0]        ptr_next
);
    int idx;
    logic found;
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (MODE == ARB_RR ? int'(ptr) : 0) + i;
            if (idx >= NUM_PORTS) idx -= NUM_PORTS;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
        ptr_next = int'(grant_idx) == NUM_PORTS - 1 ? '0 : grant_idx + 1'b1;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: N-port front end serialising 1/2/4-byte requests onto the byte-wide ram/hci bus
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int ARB_MODE       = 0,
    parameter int SIM            = 1
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            rdy_in,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS-1:0]            req_wr,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*2-1:0]          req_size,
    input  logic [NUM_PORTS*32-1:0]         req_wdata,
    output logic [NUM_PORTS-1:0]            resp_done,
    output logic [31:0]                     resp_rdata,
    output logic [ADDR_WIDTH-1:0]           mem_a,
    output logic                            mem_wr,
    output logic [7:0]                      mem_dout,
    input  logic [7:0]                      ram_din,
    input  logic [7:0]                      io_din,
    input  logic                            io_buffer_full
);
    localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
    state_t state, state_nx;
    logic [PW-1:0] ptr, ptr_next, grant_idx, port_q;
    logic [NUM_PORTS-1:0] grant;
    logic [ADDR_WIDTH-1:0] addr_q, byte_addr;
    logic [2:0] n_q, iss_cnt, cap_cnt;
    logic wr_q, cap_v_q, io_sel_q, issue, last_issue, grant_now, byte_io;
    logic [31:0] wdata_q, rdata_q, rdata_d;
    logic [7:0] cap_byte;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS), .MODE(ARB_MODE)) u_arb (
        .req(req_valid),
        .ptr(ptr),
        .grant(grant),
        .grant_idx(grant_idx),
        .ptr_next(ptr_next)
    );

    // IO writes back off while the hci tx buffer is full; reads never stall on it
    always_comb begin
        byte_addr  = addr_q + ADDR_WIDTH'(iss_cnt);
        byte_io    = byte_addr[RAM_ADDR_WIDTH -: 2] == IO_TAG;
        issue      = state == ST_XFER && rdy_in && !(wr_q && byte_io && io_buffer_full && SIM == 0);
        last_issue = issue && iss_cnt == n_q - 3'd1;
        grant_now  = state == ST_IDLE && rdy_in && |grant;
        cap_byte   = io_sel_q ? io_din : ram_din;
        rdata_d    = cap_v_q ? rdata_q | (32'(cap_byte) << {cap_cnt[1:0], 3'b000}) : rdata_q;
        state_nx   = state == ST_IDLE  ? (grant_now ? ST_XFER : ST_IDLE)
                   : state == ST_XFER  ? (!last_issue ? ST_XFER : wr_q ? ST_DONE : ST_DRAIN)
                   : state == ST_DRAIN ? (cap_v_q && cap_cnt == n_q - 3'd1 ? ST_DONE : ST_DRAIN)
                   : ST_IDLE;
        mem_a      = issue ? byte_addr : '0;
        mem_wr     = issue && wr_q;
        mem_dout   = issue && wr_q ? wdata_q[{iss_cnt[1:0], 3'b000} +: 8] : 8'h00;
        resp_done  = state == ST_DONE ? NUM_PORTS'(1) << port_q : '0;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            port_q     <= '0;
            addr_q     <= '0;
            n_q        <= 3'd1;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            iss_cnt    <= '0;
            cap_cnt    <= '0;
            cap_v_q    <= 1'b0;
            io_sel_q   <= 1'b0;
            rdata_q    <= '0;
            resp_rdata <= '0;
        end else begin
            state   <= state_nx;
            cap_v_q <= issue && !wr_q;
            rdata_q <= rdata_d;
            if (issue) begin
                io_sel_q <= byte_io;
                iss_cnt  <= iss_cnt + 3'd1;
            end
            if (cap_v_q) cap_cnt <= cap_cnt + 3'd1;
            if (state == ST_DRAIN && state_nx == ST_DONE) resp_rdata <= rdata_d;
            if (grant_now) begin
                ptr     <= ptr_next;
                port_q  <= grant_idx;
                addr_q  <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                n_q     <= size_bytes(req_size[grant_idx*2 +: 2]);
                wr_q    <= req_wr[grant_idx];
                wdata_q <= req_wdata[grant_idx*32 +: 32];
                iss_cnt <= '0;
                cap_cnt <= '0;
                rdata_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized transactions checked against a byte-level memory model
module tb_mem_bus_arbiter;
    localparam int NP = 2;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rdy, iof;
    logic [NP-1:0] req_valid, req_wr, resp_done, f_done;
    logic [NP*AW-1:0] req_addr;
    logic [NP*2-1:0] req_size;
    logic [NP*32-1:0] req_wdata;
    logic [31:0] resp_rdata, f_rdata;
    logic [AW-1:0] mem_a, f_a;
    logic mem_wr, f_wr;
    logic [7:0] mem_dout, f_dout, ram_din, io_din;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_rd;
    logic [7:0] ram [int];
    logic [7:0] ref_ram [int];
    logic [7:0] io_q [$];
    logic [7:0] exp_io_q [$];

    mem_bus_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(17), .ARB_MODE(1), .SIM(0)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .resp_done(resp_done),
        .resp_rdata(resp_rdata), .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout),
        .ram_din(ram_din), .io_din(io_din), .io_buffer_full(iof)
    );

    mem_bus_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(17), .ARB_MODE(0), .SIM(0)) dut_fix (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .resp_done(f_done),
        .resp_rdata(f_rdata), .mem_a(f_a), .mem_wr(f_wr), .mem_dout(f_dout),
        .ram_din(8'h00), .io_din(8'h00), .io_buffer_full(iof)
    );

    function automatic bit is_io(input logic [31:0] a);
        return a[17:16] == 2'b11;
    endfunction

    function automatic logic [7:0] io_fn(input logic [31:0] a);
        return a[7:0] ^ 8'hC3;
    endfunction

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + 5);
    endfunction

    function automatic logic [7:0] ref_rd(input int i);
        return ref_ram.exists(i) ? ref_ram[i] : init_byte(i);
    endfunction

    // ram and hci devices: registered read one cycle after the address, ram aliased on 4 KiB
    always @(posedge clk) begin
        int idx;
        idx = int'(mem_a[11:0]);
        ram_din <= ram.exists(idx) ? ram[idx] : init_byte(idx);
        io_din  <= io_fn(mem_a);
        if (mem_wr) begin
            if (is_io(mem_a)) io_q.push_back(mem_dout);
            else ram[idx] = mem_dout;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One request from port p; expected bus activity derives from the issue-slot rule:
    // the n bytes go out in the first n non-stalled cycles after the grant cycle
    task automatic txn(input int p, input bit wr, input logic [31:0] addr, input logic [1:0] sz,
                       input logic [31:0] wd, input int rdy_s, input int rdy_n, input int iof_n,
                       output int done_k);
        int n, issued, exp_done;
        bit stall, slot;
        logic [31:0] a, exp_rd;
        logic [7:0] b;
        n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        exp_rd = 32'h0;
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            if (wr) begin
                b = wd[8*k +: 8];
                if (is_io(a)) exp_io_q.push_back(b);
                else ref_ram[int'(a[11:0])] = b;
            end else begin
                b = is_io(a) ? io_fn(a) : ref_rd(int'(a[11:0]));
                exp_rd = exp_rd | (32'(b) << (8 * k));
            end
        end
        req_valid[p] = 1'b1;
        req_wr[p] = wr;
        req_addr[p*AW +: AW] = addr;
        req_size[p*2 +: 2] = sz;
        req_wdata[p*32 +: 32] = wd;
        @(negedge clk);
        chk("idle_done", 64'(resp_done), 64'h0);
        issued = 0;
        exp_done = -1;
        done_k = -1;
        for (int k = 1; k <= 40 && done_k < 0; k++) begin
            @(posedge clk);
            #1;
            rdy = !(k >= rdy_s && k < rdy_s + rdy_n);
            iof = k <= iof_n;
            @(negedge clk);
            a = addr + 32'(issued);
            stall = !rdy || (wr && iof && is_io(a));
            slot = issued < n && !stall;
            chk("mem_a", 64'(mem_a), slot ? 64'(a) : 64'h0);
            chk("mem_wr", 64'(mem_wr), 64'(slot && wr));
            chk("mem_dout", 64'(mem_dout), slot && wr ? 64'(wd[8*issued +: 8]) : 64'h0);
            if (slot) begin
                issued++;
                if (issued == n) exp_done = k + (wr ? 1 : 2);
            end
            chk("resp_done", 64'(resp_done), k == exp_done ? 64'(NP'(1) << p) : 64'h0);
            if (k == exp_done && !wr) last_rd = exp_rd;
            chk("resp_rdata", 64'(resp_rdata), 64'(last_rd));
            if (resp_done != '0) done_k = k;
        end
        if (done_k < 0) chk("done_timeout", 64'(done_k), 64'(exp_done));
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
        rdy = 1'b1;
        iof = 1'b0;
    endtask

    initial begin
        int dk, fx_cnt, rp, rs, rn, fn;
        bit rw;
        logic [1:0] rsz;
        logic [31:0] ra;
        logic [NP-1:0] rr_seq [$];
        logic [NP-1:0] fx_seq [$];
        logic [NP-1:0] rr_exp [6];
        logic [NP-1:0] fx_exp [6];
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10};
        fx_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
        rst_n = 1'b0;
        rdy = 1'b1;
        iof = 1'b0;
        req_valid = '0;
        req_wr = '0;
        req_addr = '0;
        req_size = '0;
        req_wdata = '0;
        last_rd = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_mem_a", 64'(mem_a), 64'h0);
        chk("rst_mem_wr", 64'(mem_wr), 64'h0);
        chk("rst_mem_dout", 64'(mem_dout), 64'h0);
        chk("rst_resp_done", 64'(resp_done), 64'h0);
        chk("rst_resp_rdata", 64'(resp_rdata), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // both ports hammer 1-byte writes: round-robin alternates, fixed priority starves port 1
        req_valid = 2'b11;
        req_wr = 2'b11;
        req_size = '0;
        req_addr = {32'h20, 32'h10};
        req_wdata = {32'hB1, 32'hA0};
        ref_ram[32'h10] = 8'hA0;
        ref_ram[32'h20] = 8'hB1;
        fx_cnt = 0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (resp_done != '0) rr_seq.push_back(resp_done);
            if (f_done != '0) begin
                fx_seq.push_back(f_done);
                fx_cnt++;
            end
            @(posedge clk);
            #1;
            if (fx_cnt == 4) req_valid[0] = 1'b0;
        end
        req_valid = '0;
        chk("rr_count", 64'(rr_seq.size()), 64'd6);
        chk("fx_count", 64'(fx_seq.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < rr_seq.size()) chk("rr_order", 64'(rr_seq[i]), 64'(rr_exp[i]));
            if (i < fx_seq.size()) chk("fx_order", 64'(fx_seq[i]), 64'(fx_exp[i]));
        end

        txn(0, 1'b1, 32'h100, 2'd2, 32'h44332211, 99, 0, 0, dk);
        chk("wr4_lat", 64'(dk), 64'd5);
        txn(0, 1'b0, 32'h100, 2'd2, 32'h0, 99, 0, 0, dk);
        chk("rd4_lat", 64'(dk), 64'd6);
        chk("rd4_data", 64'(resp_rdata), 64'h44332211);
        txn(1, 1'b1, 32'h30001, 2'd1, 32'hBEEF, 99, 0, 3, dk);
        chk("io_wr_lat", 64'(dk), 64'd6);
        txn(0, 1'b0, 32'h100, 2'd2, 32'h0, 3, 2, 0, dk);
        chk("stall_lat", 64'(dk), 64'd8);
        chk("stall_data", 64'(resp_rdata), 64'h44332211);
        txn(1, 1'b0, 32'h30000, 2'd0, 32'h0, 99, 0, 0, dk);
        chk("io_rd_lat", 64'(dk), 64'd3);
        chk("io_rd_data", 64'(resp_rdata), 64'hC3);
        txn(1, 1'b0, 32'hFFFF_FFFF, 2'd1, 32'h0, 99, 0, 0, dk);
        chk("wrap_data", 64'(resp_rdata), 64'h0000_053C);

        // reset lands while byte 2 of a 4-byte read is on the bus
        req_valid[0] = 1'b1;
        req_wr[0] = 1'b0;
        req_addr[0 +: AW] = 32'h100;
        req_size[1:0] = 2'd2;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("pre_rst_mem_a", 64'(mem_a), 64'h102);
        #1;
        rst_n = 1'b0;
        #1;
        req_valid = '0;
        last_rd = 32'h0;
        chk("arst_mem_a", 64'(mem_a), 64'h0);
        chk("arst_resp_done", 64'(resp_done), 64'h0);
        chk("arst_resp_rdata", 64'(resp_rdata), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_done", 64'(resp_done), 64'h0);
        end
        @(posedge clk);
        #1;
        txn(0, 1'b0, 32'h100, 2'd2, 32'h0, 99, 0, 0, dk);
        chk("post_rst_lat", 64'(dk), 64'd6);
        chk("post_rst_data", 64'(resp_rdata), 64'h44332211);

        for (int t = 0; t < 40; t++) begin
            rp = int'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            rsz = 2'($urandom_range(0, 3));
            ra = $urandom_range(0, 3) == 0 ? 32'h30000 + 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 4095));
            rs = int'($urandom_range(1, 5));
            rn = int'($urandom_range(0, 2));
            fn = int'($urandom_range(0, 3));
            txn(rp, rw, ra, rsz, $urandom, rs, rn, fn, dk);
        end

        repeat (2) @(negedge clk);
        chk("io_count", 64'(io_q.size()), 64'(exp_io_q.size()));
        for (int i = 0; i < exp_io_q.size() && i < io_q.size(); i++) chk("io_byte", 64'(io_q[i]), 64'(exp_io_q[i]));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
